video_region_gen: RTL and testbench



---
 rtl/video_timing_pkg.sv | 35 +++
 rtl/video_region_hit.sv | 35 +++
 rtl/video_region_gen.sv | 230 +++++++++++++++++++++++
 tb/tb_video_region_gen.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared video timing presets, pixel type and line/frame length helper
// for the raster generator and its window hit logic.
package video_timing_pkg;

    typedef logic [23:0] rgb24_t;

    localparam int DEFAULT_CW = 12;

    // 1280x720 @ 60 Hz, 74.25 MHz pixel clock
    localparam int P720_H_ACTIVE  = 1280;
    localparam int P720_H_FP      = 110;
    localparam int P720_H_SYNC    = 40;
    localparam int P720_H_BP      = 220;
    localparam int P720_V_ACTIVE  = 720;
    localparam int P720_V_FP      = 5;
    localparam int P720_V_SYNC    = 5;
    localparam int P720_V_BP      = 20;

    // 1920x1080 @ 60 Hz, 148.5 MHz pixel clock
    localparam int P1080_H_ACTIVE = 1920;
    localparam int P1080_H_FP     = 88;
    localparam int P1080_H_SYNC   = 44;
    localparam int P1080_H_BP     = 148;
    localparam int P1080_V_ACTIVE = 1080;
    localparam int P1080_V_FP     = 4;
    localparam int P1080_V_SYNC   = 5;
    localparam int P1080_V_BP     = 36;

    // Total length of a line (in pixels) or a frame (in lines).
    function automatic int total_len(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_region_hit.sv
// Rectangle hit test for one window: compares the active-area coordinate
// against the shadowed rectangle and produces the window-local coordinate.
module video_region_hit
    import video_timing_pkg::*;
#(
    parameter int CW = DEFAULT_CW
) (
    input  logic          en,
    input  logic          de,
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic [CW-1:0] rx,
    input  logic [CW-1:0] ry,
    input  logic [CW-1:0] rw,
    input  logic [CW-1:0] rh,
    output logic          hit,
    output logic [CW-1:0] lx,
    output logic [CW-1:0] ly
);

    // One extra bit so a window reaching past the coordinate range cannot wrap.
    logic [CW:0] x_end;
    logic [CW:0] y_end;

    assign x_end = {1'b0, rx} + {1'b0, rw};
    assign y_end = {1'b0, ry} + {1'b0, rh};

    assign hit = en && de
              && (x >= rx) && ({1'b0, x} < x_end)
              && (y >= ry) && ({1'b0, y} < y_end);

    assign lx = x - rx;
    assign ly = y - ry;

endmodule

// File: rtl/video_region_gen.sv
// Raster timing generator with N_REGION prioritised rectangular windows
// composited over a background colour, feeding an RGB/DE/HS/VS serializer.
module video_region_gen
    import video_timing_pkg::*;
#(
    parameter int     H_ACTIVE = P720_H_ACTIVE,
    parameter int     H_FP     = P720_H_FP,
    parameter int     H_SYNC   = P720_H_SYNC,
    parameter int     H_BP     = P720_H_BP,
    parameter int     V_ACTIVE = P720_V_ACTIVE,
    parameter int     V_FP     = P720_V_FP,
    parameter int     V_SYNC   = P720_V_SYNC,
    parameter int     V_BP     = P720_V_BP,
    parameter int     N_REGION = 2,
    parameter int     CW       = DEFAULT_CW,
    parameter bit     HS_POL   = 1'b1,
    parameter bit     VS_POL   = 1'b1,
    parameter rgb24_t BG_RGB   = 24'h000000
) (
    input  logic                   video_clk,
    input  logic                   rst,
    input  logic [N_REGION-1:0]    region_en,
    input  logic [N_REGION*CW-1:0] region_x,
    input  logic [N_REGION*CW-1:0] region_y,
    input  logic [N_REGION*CW-1:0] region_w,
    input  logic [N_REGION*CW-1:0] region_h,
    input  logic [N_REGION*24-1:0] region_rgb,
    output logic [N_REGION-1:0]    region_req,
    output logic [CW-1:0]          region_lx,
    output logic [CW-1:0]          region_ly,
    output rgb24_t                 vid_rgb,
    output logic                   vid_de,
    output logic                   vid_hs,
    output logic                   vid_vs,
    output logic                   frame_start,
    output logic                   line_start
);

    localparam int H_TOTAL = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int V_BLANK = V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    // ---------------- stage 0: counters and decode ----------------
    logic [HW-1:0] h_cnt_reg;
    logic [VW-1:0] v_cnt_reg;
    logic          h_last;
    logic          v_last;

    assign h_last = (h_cnt_reg == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt_reg == VW'(V_TOTAL - 1));

    always_ff @(posedge video_clk) begin
        if (rst) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_last) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= v_last ? '0 : v_cnt_reg + 1'b1;
        end else begin
            h_cnt_reg <= h_cnt_reg + 1'b1;
        end
    end

    logic          frame_origin;
    logic          hs_act;
    logic          vs_act;
    logic          de_act;
    logic [HW-1:0] h_off;
    logic [VW-1:0] v_off;
    logic [CW-1:0] x_pos;
    logic [CW-1:0] y_pos;

    assign frame_origin = (h_cnt_reg == '0) && (v_cnt_reg == '0);
    assign hs_act = (h_cnt_reg >= HW'(H_FP)) && (h_cnt_reg < HW'(H_FP + H_SYNC));
    assign vs_act = (v_cnt_reg >= VW'(V_FP)) && (v_cnt_reg < VW'(V_FP + V_SYNC));
    assign de_act = (h_cnt_reg >= HW'(H_BLANK)) && (v_cnt_reg >= VW'(V_BLANK));
    assign h_off  = h_cnt_reg - HW'(H_BLANK);
    assign v_off  = v_cnt_reg - VW'(V_BLANK);
    assign x_pos  = CW'(h_off);
    assign y_pos  = CW'(v_off);

    // ---------------- shadow registers and per-window hit tests ----------------
    logic [N_REGION-1:0] hit_vec;
    logic [CW-1:0]       lx_arr [N_REGION];
    logic [CW-1:0]       ly_arr [N_REGION];

    for (genvar gi = 0; gi < N_REGION; gi++) begin : g_region
        logic          sh_en_reg;
        logic [CW-1:0] sh_x_reg;
        logic [CW-1:0] sh_y_reg;
        logic [CW-1:0] sh_w_reg;
        logic [CW-1:0] sh_h_reg;

        // Geometry is only sampled at the frame origin so updates never tear.
        always_ff @(posedge video_clk) begin
            if (rst) begin
                sh_en_reg <= 1'b0;
                sh_x_reg  <= '0;
                sh_y_reg  <= '0;
                sh_w_reg  <= '0;
                sh_h_reg  <= '0;
            end else if (frame_origin) begin
                sh_en_reg <= region_en[gi];
                sh_x_reg  <= region_x[gi*CW +: CW];
                sh_y_reg  <= region_y[gi*CW +: CW];
                sh_w_reg  <= region_w[gi*CW +: CW];
                sh_h_reg  <= region_h[gi*CW +: CW];
            end
        end

        video_region_hit #(.CW(CW)) u_hit (
            .en  (sh_en_reg),
            .de  (de_act),
            .x   (x_pos),
            .y   (y_pos),
            .rx  (sh_x_reg),
            .ry  (sh_y_reg),
            .rw  (sh_w_reg),
            .rh  (sh_h_reg),
            .hit (hit_vec[gi]),
            .lx  (lx_arr[gi]),
            .ly  (ly_arr[gi])
        );
    end

    // Lowest index wins.
    logic [N_REGION-1:0] win_req;
    logic [CW-1:0]       win_lx;
    logic [CW-1:0]       win_ly;
    logic                win_found;

    always_comb begin
        win_req   = '0;
        win_lx    = '0;
        win_ly    = '0;
        win_found = 1'b0;
        for (int i = 0; i < N_REGION; i++) begin
            if (hit_vec[i] && !win_found) begin
                win_found  = 1'b1;
                win_req[i] = 1'b1;
                win_lx     = lx_arr[i];
                win_ly     = ly_arr[i];
            end
        end
    end

    // ---------------- stage 1 ----------------
    logic                de1_reg;
    logic                hs1_reg;
    logic                vs1_reg;
    logic                fs1_reg;
    logic                ls1_reg;
    logic [N_REGION-1:0] req1_reg;
    logic [CW-1:0]       lx1_reg;
    logic [CW-1:0]       ly1_reg;

    always_ff @(posedge video_clk) begin
        if (rst) begin
            de1_reg  <= 1'b0;
            hs1_reg  <= !HS_POL;
            vs1_reg  <= !VS_POL;
            fs1_reg  <= 1'b0;
            ls1_reg  <= 1'b0;
            req1_reg <= '0;
            lx1_reg  <= '0;
            ly1_reg  <= '0;
        end else begin
            de1_reg  <= de_act;
            hs1_reg  <= hs_act ? HS_POL : !HS_POL;
            vs1_reg  <= vs_act ? VS_POL : !VS_POL;
            fs1_reg  <= frame_origin;
            ls1_reg  <= (h_cnt_reg == '0);
            req1_reg <= win_req;
            lx1_reg  <= win_lx;
            ly1_reg  <= win_ly;
        end
    end

    assign region_req = req1_reg;
    assign region_lx  = lx1_reg;
    assign region_ly  = ly1_reg;

    // ---------------- stage 2 ----------------
    // The select is registered here while the pixel itself is muxed straight
    // from region_rgb, so a source with a one-cycle registered read lands on
    // the same output cycle as the rest of vid_*.
    logic                de2_reg;
    logic                hs2_reg;
    logic                vs2_reg;
    logic                fs2_reg;
    logic                ls2_reg;
    logic [N_REGION-1:0] sel2_reg;

    always_ff @(posedge video_clk) begin
        if (rst) begin
            de2_reg  <= 1'b0;
            hs2_reg  <= !HS_POL;
            vs2_reg  <= !VS_POL;
            fs2_reg  <= 1'b0;
            ls2_reg  <= 1'b0;
            sel2_reg <= '0;
        end else begin
            de2_reg  <= de1_reg;
            hs2_reg  <= hs1_reg;
            vs2_reg  <= vs1_reg;
            fs2_reg  <= fs1_reg;
            ls2_reg  <= ls1_reg;
            sel2_reg <= req1_reg;
        end
    end

    always_comb begin
        vid_rgb = de2_reg ? BG_RGB : 24'h000000;
        for (int i = 0; i < N_REGION; i++) begin
            if (sel2_reg[i]) begin
                vid_rgb = region_rgb[i*24 +: 24];
            end
        end
    end

    assign vid_de      = de2_reg;
    assign vid_hs      = hs2_reg;
    assign vid_vs      = vs2_reg;
    assign frame_start = fs2_reg;
    assign line_start  = ls2_reg;

endmodule

// File: tb/tb_video_region_gen.sv
// Self-checking bench for video_region_gen on a tiny 14x7 raster with two
// windows, checked against a coordinate-level reference model.
module tb_video_region_gen;
    import video_timing_pkg::*;

    localparam int          N      = 2;
    localparam int          CW     = 12;
    localparam int          HT     = 14;
    localparam int          VT     = 7;
    localparam int          FT     = HT * VT;
    localparam int          HB     = 6;
    localparam int          VB     = 3;
    localparam bit          HS_POL = 1'b1;
    localparam bit          VS_POL = 1'b1;
    localparam logic [23:0] BG     = 24'h0A0B0C;

    typedef struct packed {
        logic          en;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [CW-1:0] w;
        logic [CW-1:0] h;
    } win_cfg_t;

    typedef struct packed {
        logic          de;
        logic          hs;
        logic          vs;
        logic          fs;
        logic          ls;
        logic [23:0]   rgb;
        logic [N-1:0]  req;
        logic [CW-1:0] lx;
        logic [CW-1:0] ly;
    } exp_t;

    logic          video_clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]    region_en;
    logic [N*CW-1:0] region_x, region_y, region_w, region_h;
    logic [N*24-1:0] region_rgb = '0;
    logic [N-1:0]    region_req;
    logic [CW-1:0]   region_lx, region_ly;
    logic [23:0]     vid_rgb;
    logic            vid_de, vid_hs, vid_vs, frame_start, line_start;

    win_cfg_t cfg  [N];
    win_cfg_t hist [32][N];
    int       cyc = 0;
    int       checks = 0;
    int       failures = 0;

    always #5 video_clk = ~video_clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_cfg
        assign region_en[gi]            = cfg[gi].en;
        assign region_x[gi*CW +: CW]    = cfg[gi].x;
        assign region_y[gi*CW +: CW]    = cfg[gi].y;
        assign region_w[gi*CW +: CW]    = cfg[gi].w;
        assign region_h[gi*CW +: CW]    = cfg[gi].h;
    end

    video_region_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .N_REGION(N), .CW(CW), .HS_POL(HS_POL), .VS_POL(VS_POL), .BG_RGB(BG)
    ) dut (
        .video_clk   (video_clk),
        .rst         (rst),
        .region_en   (region_en),
        .region_x    (region_x),
        .region_y    (region_y),
        .region_w    (region_w),
        .region_h    (region_h),
        .region_rgb  (region_rgb),
        .region_req  (region_req),
        .region_lx   (region_lx),
        .region_ly   (region_ly),
        .vid_rgb     (vid_rgb),
        .vid_de      (vid_de),
        .vid_hs      (vid_hs),
        .vid_vs      (vid_vs),
        .frame_start (frame_start),
        .line_start  (line_start)
    );

    function automatic logic [23:0] src_pix(int i);
        return (i == 0) ? 24'h112233 : 24'h445566;
    endfunction

    // Pixel sources: one-cycle registered read, garbage when not requested.
    always @(posedge video_clk) begin
        for (int i = 0; i < N; i++)
            region_rgb[i*24 +: 24] <= region_req[i] ? src_pix(i) : 24'($urandom);
    end

    // cyc is the raster position (pixels since the frame origin that follows
    // reset); the configuration seen at each frame origin is remembered.
    always @(posedge video_clk) begin
        if (rst) begin
            cyc <= 0;
        end else begin
            if (cyc % FT == 0)
                for (int i = 0; i < N; i++) hist[(cyc / FT) % 32][i] <= cfg[i];
            cyc <= cyc + 1;
        end
    end

    // Expected raster content for raster position p.
    function automatic exp_t geom(int p);
        exp_t     e;
        win_cfg_t w;
        int h, v, x, y, win;
        e   = '0;
        h   = p % HT;
        v   = (p / HT) % VT;
        x   = h - HB;
        y   = v - VB;
        e.de = (h >= HB) && (v >= VB);
        e.hs = (h >= 2 && h < 4) ? HS_POL : !HS_POL;
        e.vs = (v >= 1 && v < 2) ? VS_POL : !VS_POL;
        e.fs = (h == 0) && (v == 0);
        e.ls = (h == 0);
        win = -1;
        for (int i = N - 1; i >= 0; i--) begin
            w = hist[(p / FT) % 32][i];
            if (w.en && e.de && x >= int'(w.x) && x < int'(w.x) + int'(w.w)
                && y >= int'(w.y) && y < int'(w.y) + int'(w.h))
                win = i;
        end
        if (win >= 0) begin
            w     = hist[(p / FT) % 32][win];
            e.req = N'(1 << win);
            e.lx  = CW'(x - int'(w.x));
            e.ly  = CW'(y - int'(w.y));
            e.rgb = src_pix(win);
        end else begin
            e.rgb = e.de ? BG : 24'h000000;
        end
        return e;
    endfunction

    function automatic logic [28:0] exp_vid(int c);
        exp_t e;
        if (c < 2) return {1'b0, !HS_POL, !VS_POL, 1'b0, 1'b0, 24'h000000};
        e = geom(c - 2);
        return {e.de, e.hs, e.vs, e.fs, e.ls, e.rgb};
    endfunction

    function automatic logic [N+2*CW-1:0] exp_req(int c);
        exp_t e;
        if (c < 1) return '0;
        e = geom(c - 1);
        return {e.req, e.lx, e.ly};
    endfunction

    task automatic test_reset();
        logic [28:0]        obs_v;
        logic [N+2*CW-1:0]  obs_r;
        rst = 1'b1;
        repeat (3) begin
            @(negedge video_clk);
            obs_v = {vid_de, vid_hs, vid_vs, frame_start, line_start, vid_rgb};
            obs_r = {region_req, region_lx, region_ly};
            checks++;
            if (obs_v !== {1'b0, !HS_POL, !VS_POL, 1'b0, 1'b0, 24'h000000}) begin
                failures++;
                $display("FAIL reset_vid got %h exp %h", obs_v, {1'b0, !HS_POL, !VS_POL, 27'h0});
            end
            checks++;
            if (obs_r !== '0) begin
                failures++;
                $display("FAIL reset_req got %h exp 0", obs_r);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_raster();
        logic [28:0] obs_v, ev;
        int hs_n = 0, de_n = 0, vs_n = 0, fs_n = 0, ls_n = 0, last_fs = -1;
        for (int k = 0; k < 2 * FT + 1; k++) begin
            @(negedge video_clk);
            obs_v = {vid_de, vid_hs, vid_vs, frame_start, line_start, vid_rgb};
            ev    = exp_vid(cyc);
            checks++;
            if (obs_v !== ev) begin
                failures++;
                $display("FAIL raster cyc=%0d got %h exp %h", cyc, obs_v, ev);
            end
            if (cyc >= 2 && cyc < 2 + 2 * FT) begin
                hs_n += (vid_hs == HS_POL) ? 1 : 0;
                vs_n += (vid_vs == VS_POL) ? 1 : 0;
                de_n += vid_de ? 1 : 0;
                ls_n += line_start ? 1 : 0;
                if (frame_start) begin
                    fs_n++;
                    if (last_fs >= 0) begin
                        checks++;
                        if (cyc - last_fs != FT) begin
                            failures++;
                            $display("FAIL frame_period got %0d exp %0d", cyc - last_fs, FT);
                        end
                    end
                    last_fs = cyc;
                end
            end
        end
        checks++;
        if (hs_n != 2 * 2 * VT || vs_n != 2 * HT || de_n != 2 * 8 * 4 || fs_n != 2 || ls_n != 2 * VT) begin
            failures++;
            $display("FAIL raster_counts got hs=%0d vs=%0d de=%0d fs=%0d ls=%0d exp hs=28 vs=28 de=64 fs=2 ls=14",
                     hs_n, vs_n, de_n, fs_n, ls_n);
        end
    endtask

    task automatic test_windows(input string name, input int ncyc);
        logic [28:0]       obs_v, ev;
        logic [N+2*CW-1:0] obs_r, er;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge video_clk);
            obs_v = {vid_de, vid_hs, vid_vs, frame_start, line_start, vid_rgb};
            obs_r = {region_req, region_lx, region_ly};
            ev    = exp_vid(cyc);
            er    = exp_req(cyc);
            checks++;
            if (obs_v !== ev) begin
                failures++;
                $display("FAIL %s_vid cyc=%0d got %h exp %h", name, cyc, obs_v, ev);
            end
            checks++;
            if (obs_r !== er) begin
                failures++;
                $display("FAIL %s_req cyc=%0d got %h exp %h", name, cyc, obs_r, er);
            end
        end
    endtask

    task automatic test_single_window();
        cfg[0] = '{en: 1'b1, x: 12'd2, y: 12'd1, w: 12'd3, h: 12'd2};
        cfg[1] = '0;
        test_windows("single", 2 * FT);
    endtask

    task automatic test_overlap();
        cfg[0] = '{en: 1'b1, x: 12'd0, y: 12'd0, w: 12'd4, h: 12'd4};
        cfg[1] = '{en: 1'b1, x: 12'd2, y: 12'd0, w: 12'd4, h: 12'd4};
        test_windows("overlap", 2 * FT);
    endtask

    task automatic test_edge_cases();
        cfg[0] = '{en: 1'b1, x: 12'd6, y: 12'd0, w: 12'd5, h: 12'd4};
        cfg[1] = '{en: 1'b1, x: 12'd4095, y: 12'd0, w: 12'd4095, h: 12'd4};
        test_windows("edge_clip", 2 * FT);
        cfg[0] = '{en: 1'b1, x: 12'd0, y: 12'd0, w: 12'd0, h: 12'd4};
        cfg[1] = '{en: 1'b0, x: 12'd0, y: 12'd0, w: 12'd8, h: 12'd4};
        test_windows("edge_off", 2 * FT);
    endtask

    task automatic test_config_change();
        int guard = 0;
        cfg[0] = '{en: 1'b1, x: 12'd1, y: 12'd1, w: 12'd2, h: 12'd2};
        cfg[1] = '0;
        test_windows("cfg_pre", FT + 10);
        while (cyc % FT != 60 && guard < 2 * FT) begin
            test_windows("cfg_wait", 1);
            guard++;
        end
        checks++;
        if (cyc % FT != 60) begin
            failures++;
            $display("FAIL cfg_wait_timeout got pos %0d exp 60", cyc % FT);
        end
        cfg[0].x = 12'd5;
        test_windows("cfg_post", 2 * FT);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < N; i++) begin
                cfg[i].en = ($urandom_range(0, 3) != 0);
                cfg[i].x  = ($urandom_range(0, 7) == 0) ? 12'(4090 + $urandom_range(0, 5)) : 12'($urandom_range(0, 9));
                cfg[i].y  = 12'($urandom_range(0, 5));
                cfg[i].w  = ($urandom_range(0, 7) == 0) ? 12'(4090 + $urandom_range(0, 5)) : 12'($urandom_range(0, 9));
                cfg[i].h  = 12'($urandom_range(0, 5));
            end
            test_windows("random", $urandom_range(40, 200));
        end
    endtask

    task automatic test_reset_midline();
        logic [28:0] obs_v;
        int guard = 0, fs_at = -1;
        cfg[0] = '{en: 1'b1, x: 12'd0, y: 12'd0, w: 12'd8, h: 12'd4};
        cfg[1] = '0;
        while (!(cyc % HT == 9 && (cyc / HT) % VT >= VB) && guard < 3 * FT) begin
            @(negedge video_clk);
            guard++;
        end
        checks++;
        if (cyc % HT != 9) begin
            failures++;
            $display("FAIL midline_wait_timeout got h=%0d exp 9", cyc % HT);
        end
        rst = 1'b1;
        @(negedge video_clk);
        obs_v = {vid_de, vid_hs, vid_vs, frame_start, line_start, vid_rgb};
        checks++;
        if (obs_v !== {1'b0, !HS_POL, !VS_POL, 1'b0, 1'b0, 24'h000000} || region_req !== '0) begin
            failures++;
            $display("FAIL midline_reset got vid=%h req=%b exp vid=%h req=0",
                     obs_v, region_req, {1'b0, !HS_POL, !VS_POL, 27'h0});
        end
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge video_clk);
            if (frame_start && fs_at < 0) fs_at = k;
        end
        checks++;
        if (fs_at != 2) begin
            failures++;
            $display("FAIL midline_fs_delay got %0d exp 2", fs_at);
        end
        test_windows("after_reset", 2 * FT);
    endtask

    initial begin
        for (int i = 0; i < N; i++) cfg[i] = '0;
        test_reset();
        test_raster();
        test_single_window();
        test_overlap();
        test_edge_cases();
        test_config_change();
        test_random();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
